// File: rtl/cluster_gen_pkg.sv
// Shared types and helpers for the synthetic cluster-rate generator.
package cluster_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MAX_CLUSTERS = 8;

    // A zero-size event would be invisible downstream, so it counts as one cluster.
    function automatic logic [3:0] clip_size(input logic [3:0] size);
        if (size == 4'd0) begin
            return 4'd1;
        end
        if (size > 4'(MAX_CLUSTERS)) begin
            return 4'(MAX_CLUSTERS);
        end
        return size;
    endfunction

endpackage

// File: rtl/rate_nco.sv
// Modulo-F phase accumulator: one tick per F/rate clocks on average, rate saturated to F.
module rate_nco #(
    parameter int unsigned g_CLK_FREQUENCY = 40079000,
    parameter int          g_COUNTER_WIDTH = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       enable,
    input  logic [g_COUNTER_WIDTH-1:0] rate,
    output logic                       tick,
    output logic                       fire
);

    localparam logic [g_COUNTER_WIDTH:0] MODULUS = (g_COUNTER_WIDTH + 1)'(g_CLK_FREQUENCY);

    logic [g_COUNTER_WIDTH:0] acc;
    logic [g_COUNTER_WIDTH:0] rate_ext;
    logic [g_COUNTER_WIDTH:0] rate_sat;
    logic [g_COUNTER_WIDTH:0] sum;

    // acc < F and rate_sat <= F, so the sum stays below 2F without overflow.
    assign rate_ext = {1'b0, rate};
    assign rate_sat = (rate_ext >= MODULUS) ? MODULUS : rate_ext;
    assign sum      = acc + rate_sat;

    // fire is the same-edge decision the parent needs for its counter and FSM.
    assign fire     = enable && (sum >= MODULUS);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            acc  <= '0;
            tick <= 1'b0;
        end else if (enable) begin
            acc  <= fire ? (sum - MODULUS) : sum;
            tick <= fire;
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/cluster_rate_generator.sv
// Synthetic cluster source: emits cluster_count increments at a programmed rate,
// continuously or as a fixed-length burst, under start/stop/resync control.
module cluster_rate_generator
    import cluster_gen_pkg::*;
#(
    parameter int unsigned g_CLK_FREQUENCY     = 40079000,
    parameter int          g_COUNTER_WIDTH     = 32,
    parameter int          g_INCREMENTER_WIDTH = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start_i,
    input  logic                           stop_i,
    input  logic                           ttc_resync,
    input  logic [g_COUNTER_WIDTH-1:0]     rate_i,
    input  logic [3:0]                     cluster_size_i,
    input  logic [g_COUNTER_WIDTH-1:0]     burst_len_i,
    output logic [g_INCREMENTER_WIDTH-1:0] cluster_count_o,
    output logic                           busy_o,
    output logic                           done_o,
    output logic [g_COUNTER_WIDTH-1:0]     events_sent_o
);

    localparam logic [g_COUNTER_WIDTH-1:0] ONE = {{(g_COUNTER_WIDTH-1){1'b0}}, 1'b1};

    state_t                     state;
    state_t                     state_next;
    logic [g_COUNTER_WIDTH-1:0] rate_q;
    logic [g_COUNTER_WIDTH-1:0] burst_q;
    logic [3:0]                 size_q;
    logic [g_COUNTER_WIDTH-1:0] events_sent;
    logic                       abort;
    logic                       accept_start;
    logic                       nco_enable;
    logic                       nco_tick;
    logic                       nco_fire;
    logic                       last_event;

    // stop and resync both win over a same-cycle start or emission.
    assign abort        = stop_i | ttc_resync;
    assign accept_start = (state == IDLE) && start_i && !abort;
    assign nco_enable   = (state == RUN) && !abort;
    assign last_event   = nco_fire && (burst_q != '0) && (events_sent == burst_q - ONE);

    rate_nco #(
        .g_CLK_FREQUENCY(g_CLK_FREQUENCY),
        .g_COUNTER_WIDTH(g_COUNTER_WIDTH)
    ) u_rate_nco (
        .clock  (clock),
        .reset  (reset),
        .clear  (accept_start),
        .enable (nco_enable),
        .rate   (rate_q),
        .tick   (nco_tick),
        .fire   (nco_fire)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept_start) state_next = RUN;
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (last_event) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            rate_q      <= '0;
            burst_q     <= '0;
            size_q      <= 4'd1;
            events_sent <= '0;
        end else begin
            state <= state_next;
            if (accept_start) begin
                rate_q  <= rate_i;
                burst_q <= burst_len_i;
                size_q  <= clip_size(cluster_size_i);
            end
            if (ttc_resync || accept_start) begin
                events_sent <= '0;
            end else if (nco_fire && (events_sent != '1)) begin
                events_sent <= events_sent + ONE;
            end
        end
    end

    // Every output is decoded from registers only, so it moves solely on clock edges.
    assign cluster_count_o = nco_tick ? g_INCREMENTER_WIDTH'(size_q) : '0;
    assign busy_o          = (state == RUN);
    assign done_o          = (state == DONE);
    assign events_sent_o   = events_sent;

endmodule

// File: tb/tb_cluster_rate_generator.sv
// Bench for cluster_rate_generator: two instances (F=10 and default F) checked
// against an arithmetic emission model plus directed literal expectations.
module tb_cluster_rate_generator;

    logic        clock;
    logic        rst     [2];
    logic        start   [2];
    logic        stop    [2];
    logic        resync  [2];
    logic [31:0] rate    [2];
    logic [3:0]  size    [2];
    logic [31:0] burst   [2];
    logic [7:0]  cc      [2];
    logic        busy    [2];
    logic        done    [2];
    logic [31:0] events  [2];

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;
    bit done_seen0 = 0;

    int exp_edges [6] = '{4, 7, 10, 14, 17, 20};

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    cluster_rate_generator #(
        .g_CLK_FREQUENCY(10)
    ) dut_a (
        .clock          (clock),
        .reset          (rst[0]),
        .start_i        (start[0]),
        .stop_i         (stop[0]),
        .ttc_resync     (resync[0]),
        .rate_i         (rate[0]),
        .cluster_size_i (size[0]),
        .burst_len_i    (burst[0]),
        .cluster_count_o(cc[0]),
        .busy_o         (busy[0]),
        .done_o         (done[0]),
        .events_sent_o  (events[0])
    );

    cluster_rate_generator dut_b (
        .clock          (clock),
        .reset          (rst[1]),
        .start_i        (start[1]),
        .stop_i         (stop[1]),
        .ttc_resync     (resync[1]),
        .rate_i         (rate[1]),
        .cluster_size_i (size[1]),
        .burst_len_i    (burst[1]),
        .cluster_count_o(cc[1]),
        .busy_o         (busy[1]),
        .done_o         (done[1]),
        .events_sent_o  (events[1])
    );

    // behavioural model: with the phase cleared at start, t cycles after start
    // exactly floor(t*r/F) events have been emitted (r saturated to F)
    function automatic longint fq(input int i);
        return (i == 0) ? 64'd10 : 64'd40079000;
    endfunction

    bit     m_run   [2];
    bit     m_done  [2];
    longint m_t     [2];
    longint m_r     [2];
    longint m_ev    [2];
    longint m_burst [2];
    int     m_sz    [2];
    int     m_cc    [2];

    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
                m_run[i] = 0; m_done[i] = 0; m_ev[i] = 0; m_cc[i] = 0;
            end else begin
                m_cc[i] = 0;
                if (m_done[i]) begin
                    m_done[i] = 0;
                    if (resync[i]) m_ev[i] = 0;
                end else if (m_run[i]) begin
                    if (stop[i] || resync[i]) begin
                        m_run[i] = 0;
                        if (resync[i]) m_ev[i] = 0;
                    end else begin
                        m_t[i] = m_t[i] + 1;
                        if ((m_t[i] * m_r[i]) / fq(i) > ((m_t[i] - 1) * m_r[i]) / fq(i)) begin
                            m_cc[i] = m_sz[i];
                            if (m_ev[i] != 64'hFFFF_FFFF) m_ev[i] = m_ev[i] + 1;
                            if (m_burst[i] != 0 && m_ev[i] == m_burst[i]) begin
                                m_run[i]  = 0;
                                m_done[i] = 1;
                            end
                        end
                    end
                end else begin
                    if (resync[i]) begin
                        m_ev[i] = 0;
                    end else if (start[i] && !stop[i]) begin
                        m_run[i]   = 1;
                        m_t[i]     = 0;
                        m_ev[i]    = 0;
                        m_r[i]     = (longint'(rate[i]) >= fq(i)) ? fq(i) : longint'(rate[i]);
                        m_sz[i]    = (size[i] == 0) ? 1 : ((size[i] > 8) ? 8 : int'(size[i]));
                        m_burst[i] = longint'(burst[i]);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    // scoreboard: every cycle, both instances against the model
    always begin
        @(posedge clock);
        #1;
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("cmp_cc_%0d", i), longint'(cc[i]), longint'(m_cc[i]));
                check($sformatf("cmp_busy_%0d", i), longint'(busy[i]), longint'(m_run[i]));
                check($sformatf("cmp_done_%0d", i), longint'(done[i]), longint'(m_done[i]));
                check($sformatf("cmp_events_%0d", i), longint'(events[i]), m_ev[i]);
            end
            if (done[0]) done_seen0 = 1;
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic start_run(input int i, input logic [31:0] r, input logic [3:0] s,
                             input logic [31:0] b);
        rate[i] = r; size[i] = s; burst[i] = b;
        start[i] = 1'b1;
        step();
        start[i] = 1'b0;
    endtask

    task automatic stop_run(input int i);
        stop[i] = 1'b1;
        step();
        stop[i] = 1'b0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; start[i] = 0; stop[i] = 0; resync[i] = 0;
            rate[i] = '0; size[i] = '0; burst[i] = '0;
        end
        step();
        chk_en = 1;
        steps(2);
        rst[0] = 1'b0; rst[1] = 1'b0;
        step();
        check("reset_cc", cc[0], 0);
        check("reset_busy", busy[0], 0);
        check("reset_done", done[1], 0);
        check("reset_events", events[1], 0);

        // F=10, rate 3: events at edges 4,7,10,14,17,20
        start_run(0, 32'd3, 4'd1, 32'd0);
        check("t1_busy_at_start", busy[0], 1);
        n = 0;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (cc[0] != 0) begin
                if (n < 6) check($sformatf("t1_event%0d_edge", n), e, exp_edges[n]);
                n++;
            end
        end
        check("t1_event_count", n, 6);
        check("t1_events_sent", events[0], 6);
        stop_run(0);
        check("t1_stopped", busy[0], 0);

        // default F, rate = F, size 5, burst 4
        start_run(1, 32'd40079000, 4'd5, 32'd4);
        for (int e = 1; e <= 4; e++) begin
            step();
            check($sformatf("t2_cc_edge%0d", e), cc[1], 5);
        end
        check("t2_busy_low", busy[1], 0);
        check("t2_done_high", done[1], 1);
        check("t2_events", events[1], 4);
        step();
        check("t2_done_pulse_end", done[1], 0);
        check("t2_cc_quiet", cc[1], 0);

        // default F at half rate
        start_run(1, 32'd20039500, 4'd3, 32'd0);
        steps(8);
        check("t2b_events", events[1], 4);
        stop_run(1);

        // rate above F, size clipping
        start_run(0, 32'd25, 4'd0, 32'd0);
        for (int e = 1; e <= 5; e++) begin
            step();
            check($sformatf("t3_size0_edge%0d", e), cc[0], 1);
        end
        check("t3_events", events[0], 5);
        stop_run(0);
        start_run(0, 32'd25, 4'd12, 32'd0);
        step();
        check("t3_size12", cc[0], 8);
        stop_run(0);

        // stop on an emission edge
        done_seen0 = 0;
        start_run(0, 32'd5, 4'd1, 32'd0);
        steps(5);
        stop_run(0);
        check("t4_cc_suppressed", cc[0], 0);
        check("t4_busy", busy[0], 0);
        check("t4_events", events[0], 2);
        step();
        check("t4_no_done", done_seen0, 0);

        // start+stop together, resync+start together, start during RUN
        rate[0] = 32'd3; start[0] = 1; stop[0] = 1;
        step();
        start[0] = 0; stop[0] = 0;
        check("t5_start_stop", busy[0], 0);
        start[0] = 1; resync[0] = 1;
        step();
        start[0] = 0; resync[0] = 0;
        check("t5_start_resync", busy[0], 0);
        start_run(0, 32'd3, 4'd1, 32'd0);
        steps(2);
        rate[0] = 32'd25; start[0] = 1;
        step();
        start[0] = 0;
        check("t5_restart_edge3", cc[0], 0);
        step();
        check("t5_edge4", cc[0], 1);
        steps(6);
        check("t5_events_edge10", events[0], 3);
        stop_run(0);

        // zero rate stays running with no events
        start_run(0, 32'd0, 4'd2, 32'd0);
        steps(15);
        check("t6_zero_busy", busy[0], 1);
        check("t6_zero_events", events[0], 0);
        stop_run(0);

        // burst of 5 at rate 7 (model-checked), then reset / resync mid-burst
        start_run(0, 32'd7, 4'd3, 32'd5);
        steps(12);
        start_run(0, 32'd5, 4'd1, 32'd10);
        steps(2);
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;
        check("t7_reset_cc", cc[0], 0);
        check("t7_reset_busy", busy[0], 0);
        check("t7_reset_events", events[0], 0);
        start_run(0, 32'd5, 4'd1, 32'd10);
        steps(2);
        check("t7_pre_resync_events", events[0], 1);
        resync[0] = 1'b1;
        step();
        resync[0] = 1'b0;
        check("t7_resync_busy", busy[0], 0);
        check("t7_resync_events", events[0], 0);
        start_run(0, 32'd3, 4'd2, 32'd2);
        steps(6);
        check("t7_edge6_busy", busy[0], 1);
        step();
        check("t7_edge7_cc", cc[0], 2);
        check("t7_edge7_done", done[0], 1);
        check("t7_edge7_events", events[0], 2);
        step();
        check("t7_edge8_done", done[0], 0);
        steps(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
